uart_bus_responder: RTL and testbench

//  Device-side responder for the CPU's UART bus strobes (rdn, wrn, data_ready, tbre, tsre).

---
 rtl/uart_bus_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_bus_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_responder.sv
// Device-side UART responder: host strobes load bytes sent as 8N1 frames on txd,
// and frames received on rxd are queued in a small FIFO that the host drains with read strobes.
module uart_bus_responder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int RX_DEPTH     = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wrn,
  input  logic       rdn,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       rx_overrun,
  input  logic       rxd,
  output logic       txd
);

  localparam int AW    = $clog2(RX_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RX_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic wrn_q, rdn_q;
  logic wr_fall, rd_fall, rd_rise;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wrn_q <= 1'b1;
      rdn_q <= 1'b1;
    end else begin
      wrn_q <= wrn;
      rdn_q <= rdn;
    end
  end

  assign wr_fall = wrn_q & ~wrn;
  assign rd_fall = rdn_q & ~rdn;
  assign rd_rise = ~rdn_q & rdn;

  // Transmit side: holding register feeding the frame shifter
  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic [7:0]    hold_data;
  logic          hold_full;

  assign tbre = ~hold_full;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state  <= IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      hold_full <= 1'b0;
      tsre      <= 1'b1;
      txd       <= 1'b1;
    end else begin
      if (wr_fall && !hold_full) begin
        hold_data <= data_in;
        hold_full <= 1'b1;
      end
      case (tx_state)
        IDLE: begin
          if (hold_full) begin
            tx_shift  <= hold_data;
            hold_full <= 1'b0;
            tsre      <= 1'b0;
            txd       <= 1'b0;
            tx_cnt    <= '0;
            tx_state  <= START;
          end
        end
        START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              txd      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            // A byte already waiting starts its frame with no idle gap
            if (hold_full) begin
              tx_shift  <= hold_data;
              hold_full <= 1'b0;
              txd       <= 1'b0;
              tx_state  <= START;
            end else begin
              tsre     <= 1'b1;
              tx_state <= IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // Receive side: synchronizer, then mid-bit sampling FSM
  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_fall;
  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_push;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_push  <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= '0;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_push  <= rx_s2;
            rx_state <= IDLE;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // RX FIFO and host read port
  logic [7:0]       mem [RX_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop_pending;
  logic             pop, full, do_write;

  assign full     = (count == FULL_CNT);
  assign pop      = rd_rise & pop_pending;
  assign do_write = rx_push & (~full | pop);

  always_ff @(posedge CLK) begin
    if (do_write) mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pop_pending <= 1'b0;
      data_out    <= 8'h00;
      data_oe     <= 1'b0;
      data_ready  <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      data_ready <= (count != '0);
      if (rd_fall) begin
        data_out    <= (count != '0) ? mem[rd_ptr] : 8'h00;
        data_oe     <= 1'b1;
        pop_pending <= (count != '0);
      end
      if (rd_rise) begin
        data_oe     <= 1'b0;
        pop_pending <= 1'b0;
      end
      if (rx_push && full && !pop) rx_overrun <= 1'b1;
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({do_write, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder: scoreboard queues hold expected TX frames and RX bytes.
module tb_uart_bus_responder;
  localparam int CPB = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wrn = 1'b1;
  logic       rdn = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe, data_ready, tbre, tsre, rx_overrun, txd;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       exp_overrun = 1'b0;
  logic       tx_abort = 1'b0;
  int         cyc = 0;
  int         idle_start_cyc = 0;
  int         tsre_rise_cyc = 0;

  uart_bus_responder #(.CLKS_PER_BIT(CPB), .RX_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .wrn(wrn), .rdn(rdn), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .data_ready(data_ready),
    .tbre(tbre), .tsre(tsre), .rx_overrun(rx_overrun), .rxd(rxd), .txd(txd)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    rx_q.delete();
    exp_overrun = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] b);
    tx_q.push_back(b);
    data_in = b;
    wrn = 1'b0;
    tick(2);
    wrn = 1'b1;
    tick(1);
  endtask

  task automatic host_read(input string tag);
    logic [7:0] exp;
    exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
    rdn = 1'b0;
    tick(1);
    chk({tag, "_oe"}, data_oe, 1'b1);
    chk({tag, "_data"}, data_out, exp);
    tick(1);
    rdn = 1'b1;
    tick(3);
    chk({tag, "_oe_off"}, data_oe, 1'b0);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input logic model);
    if (model && stop) begin
      if (rx_q.size() < 4) rx_q.push_back(b);
      else                 exp_overrun = 1'b1;
    end
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
    rxd = 1'b1;
    tick(6);
  endtask

  task automatic wait_tsre(input int limit);
    int n = 0;
    while (tsre !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    chk("tsre_wait", tsre, 1'b1);
  endtask

  // Cycle stamps: frame start from idle and return of tsre
  initial begin : stamps
    logic txd_prev, tsre_prev;
    txd_prev = 1'bx;
    tsre_prev = 1'bx;
    forever begin
      @(negedge CLK);
      cyc++;
      if (txd === 1'b0 && txd_prev === 1'b1 && tsre_prev === 1'b1) idle_start_cyc = cyc;
      if (tsre === 1'b1 && tsre_prev === 1'b0) tsre_rise_cyc = cyc;
      txd_prev = txd;
      tsre_prev = tsre;
    end
  end

  // Serial TX monitor: captures every cycle of a frame and compares against the queued byte
  initial begin : tx_mon
    logic [39:0] obs, exp;
    logic [9:0]  bits;
    logic [7:0]  b;
    logic        unexpected;
    forever begin
      @(negedge CLK);
      if (txd === 1'b0) begin
        unexpected = (tx_q.size() == 0);
        b = unexpected ? 8'h00 : tx_q.pop_front();
        obs = '0;
        obs[0] = txd;
        for (int i = 1; i < 40; i++) begin
          @(negedge CLK);
          obs[i] = txd;
        end
        if (tx_abort) begin
          tx_abort = 1'b0;
        end else if (unexpected) begin
          chk("tx_unexpected_frame", 1'b1, 1'b0);
        end else begin
          bits = {1'b1, b, 1'b0};
          for (int k = 0; k < 40; k++) exp[k] = bits[k / 4];
          chk("tx_frame", obs, exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    tick(2);
    do_reset();
    chk("rst_txd", txd, 1'b1);
    chk("rst_tbre", tbre, 1'b1);
    chk("rst_tsre", tsre, 1'b1);
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_data_oe", data_oe, 1'b0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_overrun", rx_overrun, 1'b0);
    tick(2);

    // Single frame and its exact length
    host_write(8'hA5);
    chk("t1_tsre_busy", tsre, 1'b0);
    chk("t1_tbre_free", tbre, 1'b1);
    wait_tsre(60);
    tick(1);
    chk("t1_frame_len", tsre_rise_cyc - idle_start_cyc, 40);
    tick(4);

    // Back-to-back frames
    host_write(8'h55);
    for (int n = 0; n < 20 && tbre !== 1'b1; n++) tick(1);
    host_write(8'h0F);
    chk("t2_tbre_held", tbre, 1'b0);
    chk("t2_tsre_busy", tsre, 1'b0);
    wait_tsre(120);
    tick(1);
    chk("t2_two_frame_len", tsre_rise_cyc - idle_start_cyc, 80);
    tick(4);

    // One received byte
    rx_frame(8'h3C, 1'b1, 1'b1);
    chk("t3_ready", data_ready, 1'b1);
    host_read("t3_read");
    chk("t3_ready_after", data_ready, 1'b0);

    // Overrun with five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1, 1'b1);
    chk("t4_overrun", rx_overrun, exp_overrun);
    chk("t4_ready", data_ready, 1'b1);
    for (int i = 0; i < 4; i++) host_read("t4_read");
    chk("t4_ready_after", data_ready, 1'b0);
    host_read("t4_read_empty");
    chk("t4_overrun_sticky", rx_overrun, 1'b1);

    // Glitch rejection and framing error
    do_reset();
    chk("t5_overrun_cleared", rx_overrun, 1'b0);
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(10);
    rx_frame(8'hA7, 1'b0, 1'b1);
    chk("t5_ready", data_ready, 1'b0);
    chk("t5_overrun", rx_overrun, 1'b0);

    // Reset in the middle of a TX frame and an RX frame
    rx_frame(8'h42, 1'b1, 1'b1);
    chk("t6_ready_before", data_ready, 1'b1);
    fork
      begin
        host_write(8'hC3);
        tick(12);
        chk("t6_txd_low_before", txd, 1'b0);
        tx_abort = 1'b1;
        do_reset();
        chk("t6_txd", txd, 1'b1);
        chk("t6_tbre", tbre, 1'b1);
        chk("t6_tsre", tsre, 1'b1);
        chk("t6_ready", data_ready, 1'b0);
      end
      begin
        rx_frame(8'hFF, 1'b1, 1'b0);
      end
    join
    tick(5);
    chk("t6_no_rx_push", data_ready, 1'b0);
    host_write(8'h96);
    wait_tsre(60);
    tick(1);
    chk("t6_clean_frame_len", tsre_rise_cyc - idle_start_cyc, 40);
    tick(3);
    chk("tx_queue_drained", tx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
